// File: rtl/ulpb_tx_arbiter_if.sv
// Requester-side and node-side TX handshake bundle for ulpb_tx_arbiter.
// The slave modport is the arbiter. The master modport is the environment, which is the requesters plus the node.
interface ulpb_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            REQ_REQ;
    logic [NUM_REQ-1:0]            REQ_PRIO;
    logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR;
    logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]            REQ_PEND;
    logic [NUM_REQ-1:0]            REQ_ACK;
    logic [NUM_REQ-1:0]            REQ_SUCC;
    logic [NUM_REQ-1:0]            REQ_FAIL;
    logic [NUM_REQ-1:0]            REQ_RESP_ACK;
    logic [ADDR_WIDTH-1:0]         TX_ADDR;
    logic [DATA_WIDTH-1:0]         TX_DATA;
    logic                          TX_PEND;
    logic                          TX_REQ;
    logic                          PRIORITY;
    logic                          TX_ACK;
    logic                          TX_SUCC;
    logic                          TX_FAIL;
    logic                          TX_RESP_ACK;

    modport slave (
        input  REQ_REQ, REQ_PRIO, REQ_ADDR, REQ_DATA, REQ_PEND, REQ_RESP_ACK,
        input  TX_ACK, TX_SUCC, TX_FAIL,
        output REQ_ACK, REQ_SUCC, REQ_FAIL,
        output TX_ADDR, TX_DATA, TX_PEND, TX_REQ, PRIORITY, TX_RESP_ACK
    );

    modport master (
        output REQ_REQ, REQ_PRIO, REQ_ADDR, REQ_DATA, REQ_PEND, REQ_RESP_ACK,
        output TX_ACK, TX_SUCC, TX_FAIL,
        input  REQ_ACK, REQ_SUCC, REQ_FAIL,
        input  TX_ADDR, TX_DATA, TX_PEND, TX_REQ, PRIORITY, TX_RESP_ACK
    );
endinterface

// File: rtl/ulpb_tx_arbiter.sv
// Shares one ulpb_node32 TX port among NUM_REQ requesters.
// The grant is held for a whole multi-word message and for its result handshake.
module ulpb_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic             CLKIN,
    input  logic             RESET,
    ulpb_tx_arbiter_if.slave bus
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_RES, RESP} state_t;

    state_t               state;
    logic [GW-1:0]        gnt;
    logic [GW-1:0]        ptr;
    logic [GW-1:0]        ptr_next;
    logic                 last_word;
    logic                 acked;
    logic                 resp_ack;
    logic [NUM_REQ-1:0]   succ;
    logic [NUM_REQ-1:0]   fail;
    logic [NUM_REQ-1:0]   ack_vec;
    logic                 on_msg;
    logic                 tx_req;
    logic                 tx_pend;
    logic                 node_clr;
    logic                 req_clr;

    // The scan runs downward so that the lowest offset from start wins. Priority requesters beat plain ones.
    function automatic logic [GW-1:0] pick(input logic [NUM_REQ-1:0] req,
                                           input logic [NUM_REQ-1:0] prio,
                                           input logic [GW-1:0]      start);
        logic [GW-1:0] any_idx;
        logic [GW-1:0] pri_idx;
        logic [GW-1:0] idx;
        logic          has_pri;
        any_idx = '0;
        pri_idx = '0;
        has_pri = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = GW'((int'(start) + k) % NUM_REQ);
            if (req[idx]) begin
                any_idx = idx;
                if (prio[idx]) begin
                    pri_idx = idx;
                    has_pri = 1'b1;
                end
            end
        end
        return has_pri ? pri_idx : any_idx;
    endfunction

    assign on_msg   = (state == ACTIVE) || (state == WAIT_RES);
    assign tx_req   = (state == ACTIVE) && bus.REQ_REQ[gnt];
    assign tx_pend  = on_msg && bus.REQ_PEND[gnt];
    assign ptr_next = (gnt == GW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;

    assign bus.TX_REQ      = tx_req;
    assign bus.TX_PEND     = tx_pend;
    assign bus.PRIORITY    = on_msg && bus.REQ_PRIO[gnt];
    assign bus.TX_ADDR     = on_msg ? bus.REQ_ADDR[int'(gnt)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign bus.TX_DATA     = on_msg ? bus.REQ_DATA[int'(gnt)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.TX_RESP_ACK = resp_ack;
    assign bus.REQ_SUCC    = succ;
    assign bus.REQ_FAIL    = fail;
    assign bus.REQ_ACK     = ack_vec;

    // After an abort no word is in flight, so a stray TX_ACK must not reach the requester.
    always_comb begin
        ack_vec = '0;
        if (state == ACTIVE)
            ack_vec[gnt] = bus.TX_ACK;
        else if (state == WAIT_RES)
            ack_vec[gnt] = bus.TX_ACK & last_word;
    end

    assign node_clr = !resp_ack || !(bus.TX_SUCC || bus.TX_FAIL);
    assign req_clr  = !(succ[gnt] || fail[gnt]) || bus.REQ_RESP_ACK[gnt];

    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            gnt       <= '0;
            ptr       <= '0;
            last_word <= 1'b0;
            acked     <= 1'b0;
            resp_ack  <= 1'b0;
            succ      <= '0;
            fail      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    last_word <= 1'b0;
                    acked     <= 1'b0;
                    if (|bus.REQ_REQ) begin
                        gnt   <= pick(bus.REQ_REQ, bus.REQ_PRIO, ptr);
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (bus.TX_FAIL) begin
                        state <= WAIT_RES;
                    end else if (tx_req && bus.TX_ACK) begin
                        acked <= 1'b1;
                        if (!tx_pend) begin
                            last_word <= 1'b1;
                            state     <= WAIT_RES;
                        end
                    end else if (!bus.REQ_REQ[gnt] && !acked) begin
                        state <= IDLE;
                    end
                end
                WAIT_RES: begin
                    if (bus.TX_SUCC || bus.TX_FAIL) begin
                        fail[gnt] <= bus.TX_FAIL;
                        succ[gnt] <= bus.TX_SUCC && !bus.TX_FAIL;
                        resp_ack  <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (node_clr)
                        resp_ack <= 1'b0;
                    if (bus.REQ_RESP_ACK[gnt]) begin
                        succ[gnt] <= 1'b0;
                        fail[gnt] <= 1'b0;
                    end
                    if (node_clr && req_clr) begin
                        ptr   <= ptr_next;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ulpb_tx_arbiter.sv
// Self-checking bench for ulpb_tx_arbiter. A table of single-requester messages is followed by contention, withdrawal and reset sequences.
module tb_ulpb_tx_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 32;

    logic CLKIN = 1'b0;
    logic RESET;

    ulpb_tx_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ulpb_tx_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLKIN (CLKIN),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLKIN = ~CLKIN;

    typedef struct {
        logic [1:0]    owner;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          pend;
        logic          prio;
    } word_t;

    typedef struct {
        logic [1:0] owner;
        int         fail_at;
        logic       both;
        logic [3:0] succ;
        logic [3:0] fail;
    } res_t;

    typedef struct {
        logic [1:0]    id;
        logic          prio;
        int            nwords;
        int            fail_at;
        logic          both;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [3:0]    exp_succ;
        logic [3:0]    exp_fail;
    } vec_t;

    word_t sb[$];
    res_t  res_q[$];
    vec_t  vt[6];

    logic [AW-1:0] r_addr[N];
    logic [DW-1:0] r_data[N];
    int            r_words[N];
    int            r_w[N];
    logic          r_prio[N];

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    task automatic tick();
        @(negedge CLKIN);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic [1:0] id);
        bus.REQ_ADDR[int'(id)*AW +: AW] = r_addr[id];
        bus.REQ_DATA[int'(id)*DW +: DW] = r_data[id] + DW'(r_w[id]);
        bus.REQ_PEND[id] = (r_w[id] < r_words[id] - 1);
        bus.REQ_PRIO[id] = r_prio[id];
    endtask

    task automatic raise(input logic [1:0] id, input logic prio, input int nwords,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        r_addr[id]  = addr;
        r_data[id]  = data;
        r_words[id] = nwords;
        r_w[id]     = 0;
        r_prio[id]  = prio;
        drive_req(id);
        bus.REQ_REQ[id] = 1'b1;
    endtask

    task automatic push_msg(input logic [1:0] id, input int fail_at, input logic both,
                            input logic [3:0] es, input logic [3:0] ef);
        word_t x;
        res_t  r;
        int    n;
        n = (fail_at < 0) ? r_words[id] : fail_at;
        for (int w = 0; w < n; w++) begin
            x.owner = id;
            x.addr  = r_addr[id];
            x.data  = r_data[id] + DW'(w);
            x.pend  = (w < r_words[id] - 1);
            x.prio  = r_prio[id];
            sb.push_back(x);
        end
        r.owner = id; r.fail_at = fail_at; r.both = both; r.succ = es; r.fail = ef;
        res_q.push_back(r);
    endtask

    task automatic wait_txreq(output int l);
        l = 0;
        while (bus.TX_REQ !== 1'b1 && l < 20) begin
            tick();
            l++;
        end
        chk("tx_req_seen", 64'(bus.TX_REQ), 64'(1));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_tx_req"},   64'(bus.TX_REQ), 64'(0));
        chk({tag, "_tx_addr"},  64'(bus.TX_ADDR), 64'(0));
        chk({tag, "_tx_data"},  64'(bus.TX_DATA), 64'(0));
        chk({tag, "_tx_pend"},  64'(bus.TX_PEND), 64'(0));
        chk({tag, "_priority"}, 64'(bus.PRIORITY), 64'(0));
        chk({tag, "_req_ack"},  64'(bus.REQ_ACK), 64'(0));
        chk({tag, "_req_succ"}, 64'(bus.REQ_SUCC), 64'(0));
        chk({tag, "_req_fail"}, 64'(bus.REQ_FAIL), 64'(0));
        chk({tag, "_resp_ack"}, 64'(bus.TX_RESP_ACK), 64'(0));
    endtask

    // Plays the node and the granted requester through one message. The expected words and result come from the queues.
    task automatic node_msg(output int first_lat);
        res_t  r;
        word_t w;
        int    acked;
        int    l;
        bit    done;
        first_lat = -1;
        if (res_q.size() == 0) begin
            chk("res_queue_nonempty", 64'(0), 64'(1));
            return;
        end
        r = res_q.pop_front();
        acked = 0;
        done = 0;
        while (!done) begin
            wait_txreq(l);
            if (first_lat < 0) first_lat = l;
            if (r.fail_at == acked) begin
                chk("abort_no_ack", 64'(bus.REQ_ACK), 64'(0));
                bus.TX_FAIL = 1'b1;
                tick();
                chk("abort_tx_req_low", 64'(bus.TX_REQ), 64'(0));
                chk("abort_no_ack_wait", 64'(bus.REQ_ACK), 64'(0));
                tick();
                done = 1;
            end else begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 64'(0), 64'(1));
                    return;
                end
                w = sb.pop_front();
                chk("tx_addr", 64'(bus.TX_ADDR), 64'(w.addr));
                chk("tx_data", 64'(bus.TX_DATA), 64'(w.data));
                chk("tx_pend", 64'(bus.TX_PEND), 64'(w.pend));
                chk("priority", 64'(bus.PRIORITY), 64'(w.prio));
                chk("req_ack_idle", 64'(bus.REQ_ACK), 64'(0));
                bus.TX_ACK = 1'b1;
                tick();
                chk("req_ack_route", 64'(bus.REQ_ACK), 64'(4'b0001 << w.owner));
                bus.REQ_REQ[w.owner] = 1'b0;
                tick();
                chk("req_ack_hold", 64'(bus.REQ_ACK), 64'(4'b0001 << w.owner));
                chk("tx_req_gap", 64'(bus.TX_REQ), 64'(0));
                bus.TX_ACK = 1'b0;
                tick();
                acked++;
                if (!w.pend) begin
                    bus.TX_SUCC = 1'b1;
                    bus.TX_FAIL = r.both;
                    tick();
                    done = 1;
                end else begin
                    r_w[w.owner]++;
                    drive_req(w.owner);
                    bus.REQ_REQ[w.owner] = 1'b1;
                end
            end
        end
        chk("res_succ", 64'(bus.REQ_SUCC), 64'(r.succ));
        chk("res_fail", 64'(bus.REQ_FAIL), 64'(r.fail));
        chk("resp_ack_up", 64'(bus.TX_RESP_ACK), 64'(1));
        bus.TX_SUCC = 1'b0;
        bus.TX_FAIL = 1'b0;
        bus.REQ_REQ[r.owner] = 1'b0;
        tick();
        chk("resp_ack_down", 64'(bus.TX_RESP_ACK), 64'(0));
        chk("res_succ_held", 64'(bus.REQ_SUCC), 64'(r.succ));
        chk("res_fail_held", 64'(bus.REQ_FAIL), 64'(r.fail));
        bus.REQ_RESP_ACK[r.owner] = 1'b1;
        tick();
        chk("res_succ_clr", 64'(bus.REQ_SUCC), 64'(0));
        chk("res_fail_clr", 64'(bus.REQ_FAIL), 64'(0));
        bus.REQ_RESP_ACK[r.owner] = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt[0] = '{2'd1, 1'b0, 1, -1, 1'b0, 8'h5A, 32'hDEADBEEF, 4'b0010, 4'b0000};
        vt[1] = '{2'd3, 1'b1, 2, -1, 1'b0, 8'hC3, 32'h3333_0000, 4'b1000, 4'b0000};
        vt[2] = '{2'd0, 1'b0, 2,  1, 1'b0, 8'h0F, 32'h0000_AAA0, 4'b0000, 4'b0001};
        vt[3] = '{2'd2, 1'b0, 3, -1, 1'b0, 8'h24, 32'h2222_1110, 4'b0100, 4'b0000};
        vt[4] = '{2'd1, 1'b1, 1,  0, 1'b0, 8'h99, 32'h9999_9999, 4'b0000, 4'b0010};
        vt[5] = '{2'd0, 1'b0, 1, -1, 1'b1, 8'hE1, 32'h0E0E_0E0E, 4'b0000, 4'b0001};

        bus.REQ_REQ = '0; bus.REQ_PRIO = '0; bus.REQ_ADDR = '0; bus.REQ_DATA = '0;
        bus.REQ_PEND = '0; bus.REQ_RESP_ACK = '0;
        bus.TX_ACK = 1'b0; bus.TX_SUCC = 1'b0; bus.TX_FAIL = 1'b0;
        RESET = 1'b1;
        tick();
        tick();
        chk_quiet("reset");
        RESET = 1'b0;
        tick();

        foreach (vt[i]) begin
            raise(vt[i].id, vt[i].prio, vt[i].nwords, vt[i].addr, vt[i].data);
            push_msg(vt[i].id, vt[i].fail_at, vt[i].both, vt[i].exp_succ, vt[i].exp_fail);
            node_msg(lat);
            chk($sformatf("vec%0d_select_latency", i), 64'(lat), 64'(1));
        end

        // Round robin from ptr=0. Order 0, 2, 0, after which ptr=1 favours 1 over 0.
        do_reset();
        raise(2'd0, 1'b0, 1, 8'h10, 32'h1000_0000);
        raise(2'd2, 1'b0, 1, 8'h30, 32'h3000_0000);
        push_msg(2'd0, -1, 1'b0, 4'b0001, 4'b0000);
        push_msg(2'd2, -1, 1'b0, 4'b0100, 4'b0000);
        node_msg(lat);
        raise(2'd0, 1'b0, 1, 8'h11, 32'h1000_0100);
        push_msg(2'd0, -1, 1'b0, 4'b0001, 4'b0000);
        node_msg(lat);
        node_msg(lat);
        raise(2'd0, 1'b0, 1, 8'h12, 32'h1000_0200);
        raise(2'd1, 1'b0, 1, 8'h21, 32'h2100_0000);
        push_msg(2'd1, -1, 1'b0, 4'b0010, 4'b0000);
        push_msg(2'd0, -1, 1'b0, 4'b0001, 4'b0000);
        node_msg(lat);
        node_msg(lat);

        // Priority wins over round robin, and a late priority request does not preempt.
        do_reset();
        raise(2'd1, 1'b0, 1, 8'h41, 32'h4100_0000);
        raise(2'd3, 1'b1, 2, 8'h43, 32'h4300_0000);
        tick();
        r_prio[1] = 1'b1;
        drive_req(2'd1);
        push_msg(2'd3, -1, 1'b0, 4'b1000, 4'b0000);
        push_msg(2'd1, -1, 1'b0, 4'b0010, 4'b0000);
        node_msg(lat);
        node_msg(lat);

        // A three-word message from requester 2 holds the grant while requester 0 waits.
        do_reset();
        raise(2'd2, 1'b0, 3, 8'h52, 32'h5200_0000);
        tick();
        raise(2'd0, 1'b0, 1, 8'h50, 32'h5000_0000);
        push_msg(2'd2, -1, 1'b0, 4'b0100, 4'b0000);
        push_msg(2'd0, -1, 1'b0, 4'b0001, 4'b0000);
        node_msg(lat);
        node_msg(lat);

        // Withdrawal before the first ack returns to IDLE and leaves ptr at 3.
        do_reset();
        raise(2'd2, 1'b0, 1, 8'h62, 32'h6200_0000);
        push_msg(2'd2, -1, 1'b0, 4'b0100, 4'b0000);
        node_msg(lat);
        raise(2'd3, 1'b0, 1, 8'h77, 32'h7700_0000);
        tick();
        chk("wd_tx_addr_active", 64'(bus.TX_ADDR), 64'(8'h77));
        bus.REQ_REQ[3] = 1'b0;
        tick();
        chk("wd_tx_addr_gated", 64'(bus.TX_ADDR), 64'(0));
        chk("wd_tx_req", 64'(bus.TX_REQ), 64'(0));
        raise(2'd0, 1'b0, 1, 8'h70, 32'h7000_0000);
        raise(2'd3, 1'b0, 1, 8'h78, 32'h7800_0000);
        push_msg(2'd3, -1, 1'b0, 4'b1000, 4'b0000);
        push_msg(2'd0, -1, 1'b0, 4'b0001, 4'b0000);
        node_msg(lat);
        node_msg(lat);

        // Asynchronous reset mid-word clears outputs and ptr. A fresh request then completes.
        do_reset();
        raise(2'd0, 1'b0, 1, 8'h80, 32'h8000_0000);
        push_msg(2'd0, -1, 1'b0, 4'b0001, 4'b0000);
        node_msg(lat);
        raise(2'd2, 1'b0, 2, 8'h82, 32'h8200_0000);
        wait_txreq(lat);
        bus.TX_ACK = 1'b1;
        #1;
        RESET = 1'b1;
        #1;
        chk_quiet("reset_mid");
        tick();
        bus.REQ_REQ[2] = 1'b0;
        bus.TX_ACK = 1'b0;
        tick();
        RESET = 1'b0;
        tick();
        chk_quiet("after_reset");
        raise(2'd1, 1'b0, 1, 8'h91, 32'h9100_0000);
        raise(2'd0, 1'b0, 1, 8'h90, 32'h9000_0000);
        push_msg(2'd0, -1, 1'b0, 4'b0001, 4'b0000);
        push_msg(2'd1, -1, 1'b0, 4'b0010, 4'b0000);
        node_msg(lat);
        node_msg(lat);

        chk("sb_drained", 64'(sb.size()), 64'(0));
        chk("res_drained", 64'(res_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
